// File: rtl/ic_cpu_bus_sram_responder.sv
// ---------------------------------------------------------------------------
// ic_cpu_bus_sram_responder
//
// Target end of the CPU memory bus. Accepts one request at a time on the
// req/gnt channel, performs a single access on a single-port synchronous
// SRAM (1-cycle read latency), and returns the result on the recv/ack channel.
// Requests that fall outside the [BASE_ADDR, BASE_ADDR+SIZE) window receive an
// error response without touching the SRAM.
//
// Ports
//   g_clk, g_resetn      clock, synchronous active-low reset
//   s_mem_req            request valid
//   s_mem_wen            1 = write, 0 = read
//   s_mem_strb[3:0]      byte write strobes
//   s_mem_wdata[31:0]    write data
//   s_mem_addr[31:0]     byte address
//   s_mem_gnt            request accepted this cycle (high whenever idle)
//   s_mem_recv           response valid
//   s_mem_ack            initiator accepts response
//   s_mem_error          response is an error
//   s_mem_rdata[31:0]    read data (0 for writes and errors)
//   sram_cen             SRAM access enable (one cycle per access)
//   sram_wstrb[3:0]      SRAM byte write enables (0 = read)
//   sram_addr[SW-1:0]    SRAM word address
//   sram_wdata[31:0]     SRAM write data
//   sram_rdata[31:0]     SRAM read data, valid the cycle after sram_cen
// ---------------------------------------------------------------------------
module ic_cpu_bus_sram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] SIZE        = 32'h0001_0000,
  parameter int unsigned WAIT_CYCLES = 0,
  localparam int         SW          = $clog2(SIZE / 4)
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  input  logic          s_mem_req,
  input  logic          s_mem_wen,
  input  logic [3:0]    s_mem_strb,
  input  logic [31:0]   s_mem_wdata,
  input  logic [31:0]   s_mem_addr,
  output logic          s_mem_gnt,
  output logic          s_mem_recv,
  input  logic          s_mem_ack,
  output logic          s_mem_error,
  output logic [31:0]   s_mem_rdata,
  output logic          sram_cen,
  output logic [3:0]    sram_wstrb,
  output logic [SW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_CAPTURE,
    ST_WAIT,
    ST_RSP
  } state_t;

  // The counter runs WAIT_LOAD..0 inclusive, i.e. exactly WAIT_CYCLES cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t        state_q, state_d;
  logic          wen_q;
  logic [3:0]    strb_q;
  logic [31:0]   wdata_q;
  logic [SW-1:0] widx_q;
  logic          error_q;
  logic [31:0]   rdata_q;
  logic [3:0]    wait_q;

  // Offset from the window base. Because BASE_ADDR is SIZE-aligned, an address
  // below the base wraps to a value >= SIZE, so one unsigned compare covers
  // both ends of the window and is safe even when the window ends at 2^32.
  logic [31:0] offset;
  logic        in_range;

  assign offset   = s_mem_addr - BASE_ADDR;
  assign in_range = (offset < SIZE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q <= ST_IDLE;
      wen_q   <= 1'b0;
      strb_q  <= 4'b0;
      wdata_q <= 32'b0;
      widx_q  <= '0;
      error_q <= 1'b0;
      rdata_q <= 32'b0;
      wait_q  <= 4'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          // gnt is high throughout IDLE, so a req here is an accepted request.
          if (s_mem_req) begin
            wen_q   <= s_mem_wen;
            strb_q  <= s_mem_strb;
            wdata_q <= s_mem_wdata;
            widx_q  <= offset[SW+1:2];
            error_q <= !in_range;
            rdata_q <= 32'b0;
          end
        end
        ST_CAPTURE: begin
          rdata_q <= wen_q ? 32'b0 : sram_rdata;
          wait_q  <= WAIT_LOAD;
        end
        ST_WAIT: begin
          if (wait_q != 4'd0) wait_q <= wait_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every signal driven here is given a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (s_mem_req) state_d = in_range ? ST_ACCESS : ST_RSP;
      ST_ACCESS:  state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RSP;
      ST_WAIT:    if (wait_q == 4'd0) state_d = ST_RSP;
      ST_RSP:     if (s_mem_ack) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, even though the registered
  // state only changes at the next edge.
  always_comb begin
    s_mem_gnt   = 1'b0;
    s_mem_recv  = 1'b0;
    s_mem_error = 1'b0;
    s_mem_rdata = 32'b0;
    sram_cen    = 1'b0;
    sram_wstrb  = 4'b0;
    sram_addr   = widx_q;
    sram_wdata  = wdata_q;
    if (g_resetn) begin
      s_mem_gnt = (state_q == ST_IDLE);
      if (state_q == ST_RSP) begin
        s_mem_recv  = 1'b1;
        s_mem_error = error_q;
        s_mem_rdata = rdata_q;
      end
      if (state_q == ST_ACCESS) begin
        sram_cen   = 1'b1;
        sram_wstrb = wen_q ? strb_q : 4'b0;
      end
    end
  end

endmodule

// File: tb/tb_ic_cpu_bus_sram_responder.sv
// ---------------------------------------------------------------------------
// Testbench for ic_cpu_bus_sram_responder.
// dut0: BASE 0x1000, SIZE 0x100, no wait states.
// dut1: same window, WAIT_CYCLES = 2.
// Each DUT drives its own behavioural SRAM (1-cycle read latency), which is
// reloaded with fixed contents while reset is low.
// ---------------------------------------------------------------------------
module tb_ic_cpu_bus_sram_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] SZ   = 32'h0000_0100;

  logic clk;
  logic resetn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut0 signals
  logic        req0, wen0, ack0;
  logic [3:0]  strb0;
  logic [31:0] wdata0, addr0;
  logic        gnt0, recv0, err0, cen0;
  logic [31:0] rdata0, swdata0, srdata0;
  logic [3:0]  wstrb0;
  logic [5:0]  saddr0;

  // dut1 signals
  logic        req1, wen1, ack1;
  logic [3:0]  strb1;
  logic [31:0] wdata1, addr1;
  logic        gnt1, recv1, err1, cen1;
  logic [31:0] rdata1, swdata1, srdata1;
  logic [3:0]  wstrb1;
  logic [5:0]  saddr1;

  ic_cpu_bus_sram_responder #(.BASE_ADDR(BASE), .SIZE(SZ), .WAIT_CYCLES(0)) dut0 (
    .g_clk(clk), .g_resetn(resetn),
    .s_mem_req(req0), .s_mem_wen(wen0), .s_mem_strb(strb0), .s_mem_wdata(wdata0),
    .s_mem_addr(addr0), .s_mem_gnt(gnt0), .s_mem_recv(recv0), .s_mem_ack(ack0),
    .s_mem_error(err0), .s_mem_rdata(rdata0),
    .sram_cen(cen0), .sram_wstrb(wstrb0), .sram_addr(saddr0),
    .sram_wdata(swdata0), .sram_rdata(srdata0)
  );

  ic_cpu_bus_sram_responder #(.BASE_ADDR(BASE), .SIZE(SZ), .WAIT_CYCLES(2)) dut1 (
    .g_clk(clk), .g_resetn(resetn),
    .s_mem_req(req1), .s_mem_wen(wen1), .s_mem_strb(strb1), .s_mem_wdata(wdata1),
    .s_mem_addr(addr1), .s_mem_gnt(gnt1), .s_mem_recv(recv1), .s_mem_ack(ack1),
    .s_mem_error(err1), .s_mem_rdata(rdata1),
    .sram_cen(cen1), .sram_wstrb(wstrb1), .sram_addr(saddr1),
    .sram_wdata(swdata1), .sram_rdata(srdata1)
  );

  // Behavioural SRAMs plus access counters.
  logic [31:0] mem0 [64];
  logic [31:0] mem1 [64];
  int          cen_cnt0 = 0;

  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 64; i++) mem0[i] <= 32'h0;
      mem0[0] <= 32'h1122_3344;
      mem0[2] <= 32'hFFFF_FFFF;
      mem0[4] <= 32'hDEAD_BEEF;
    end else if (cen0) begin
      for (int b = 0; b < 4; b++)
        if (wstrb0[b]) mem0[saddr0][8*b +: 8] <= swdata0[8*b +: 8];
      srdata0  <= mem0[saddr0];
      cen_cnt0 <= cen_cnt0 + 1;
    end
  end

  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 64; i++) mem1[i] <= 32'h0;
      mem1[4] <= 32'hCAFE_F00D;
    end else if (cen1) begin
      for (int b = 0; b < 4; b++)
        if (wstrb1[b]) mem1[saddr1][8*b +: 8] <= swdata1[8*b +: 8];
      srdata1 <= mem1[saddr1];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        wen;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [5:0]  exp_widx;
  } vec_t;

  // One full transaction on dut0 with latency, SRAM-side and response checks.
  task automatic run_txn(input vec_t v, input string tag);
    int n;
    int lat;
    int cen_before;
    req0 = 1'b1; wen0 = v.wen; strb0 = v.strb; wdata0 = v.wdata; addr0 = v.addr;
    ack0 = 1'b0;
    n = 0;
    while (!gnt0 && n < 20) begin step(); n++; end
    check({tag, " gnt"}, gnt0, 1);
    cen_before = cen_cnt0;
    step();
    req0 = 1'b0;
    check({tag, " cen@T+1"}, cen0, !v.exp_err);
    if (!v.exp_err) begin
      check({tag, " wstrb"}, wstrb0, v.wen ? v.strb : 4'b0);
      check({tag, " sram_addr"}, saddr0, v.exp_widx);
    end
    lat = 1;
    while (!recv0 && lat < 30) begin step(); lat++; end
    check({tag, " latency"}, lat, v.exp_err ? 1 : 3);
    check({tag, " error"}, err0, v.exp_err);
    check({tag, " rdata"}, rdata0, v.exp_rdata);
    ack0 = 1'b1;
    step();
    ack0 = 1'b0;
    check({tag, " sram accesses"}, cen_cnt0 - cen_before, v.exp_err ? 0 : 1);
  endtask

  vec_t vecs [12];

  initial begin
    int n;
    int cyc_g [3];
    int ng;
    int first_recv;
    int recv_seen;
    logic [31:0] rd1;

    //         wen  strb   wdata          addr           err  rdata          widx
    vecs[0]  = '{1'b0, 4'h0, 32'h0,         32'h0000_1010, 1'b0, 32'hDEAD_BEEF, 6'd4};
    vecs[1]  = '{1'b1, 4'h3, 32'h1234_5678, 32'h0000_1008, 1'b0, 32'h0,         6'd2};
    vecs[2]  = '{1'b0, 4'h0, 32'h0,         32'h0000_1008, 1'b0, 32'hFFFF_5678, 6'd2};
    vecs[3]  = '{1'b0, 4'h0, 32'h0,         32'h0000_100B, 1'b0, 32'hFFFF_5678, 6'd2};
    vecs[4]  = '{1'b1, 4'hF, 32'hA5A5_0001, 32'h0000_10FC, 1'b0, 32'h0,         6'd63};
    vecs[5]  = '{1'b0, 4'h0, 32'h0,         32'h0000_10FC, 1'b0, 32'hA5A5_0001, 6'd63};
    vecs[6]  = '{1'b0, 4'h0, 32'h0,         32'h0000_1100, 1'b1, 32'h0,         6'd0};
    vecs[7]  = '{1'b0, 4'h0, 32'h0,         32'h0000_0FFC, 1'b1, 32'h0,         6'd0};
    vecs[8]  = '{1'b1, 4'h0, 32'h0,         32'h0000_1010, 1'b0, 32'h0,         6'd4};
    vecs[9]  = '{1'b0, 4'h0, 32'h0,         32'h0000_1010, 1'b0, 32'hDEAD_BEEF, 6'd4};
    vecs[10] = '{1'b1, 4'hF, 32'h5555_5555, 32'hFFFF_FFFC, 1'b1, 32'h0,         6'd0};
    vecs[11] = '{1'b0, 4'h0, 32'h0,         32'h0000_1000, 1'b0, 32'h1122_3344, 6'd0};

    resetn = 1'b0;
    req0 = 1'b0; wen0 = 1'b0; strb0 = 4'h0; wdata0 = 32'h0; addr0 = 32'h0; ack0 = 1'b0;
    req1 = 1'b0; wen1 = 1'b0; strb1 = 4'h0; wdata1 = 32'h0; addr1 = 32'h0; ack1 = 1'b0;
    step(); step(); step();

    // Reset state: everything quiet while reset is held.
    check("rst gnt0",  gnt0,   0);
    check("rst recv0", recv0,  0);
    check("rst err0",  err0,   0);
    check("rst rdata0", rdata0, 32'h0);
    check("rst cen0",  cen0,   0);
    check("rst gnt1",  gnt1,   0);
    resetn = 1'b1;
    #1;
    check("post-rst gnt0", gnt0, 1);

    // Table-driven transactions on dut0.
    for (int i = 0; i < 12; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Ack stall with a second request held high.
    req0 = 1'b1; wen0 = 1'b0; addr0 = 32'h0000_1010; ack0 = 1'b0;
    n = 0;
    while (!gnt0 && n < 20) begin step(); n++; end
    check("stall gnt", gnt0, 1);
    step();
    addr0 = 32'h0000_1008;
    n = 0;
    while (!recv0 && n < 30) begin step(); n++; end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d recv", k),  recv0,  1);
      check($sformatf("stall%0d rdata", k), rdata0, 32'hDEAD_BEEF);
      check($sformatf("stall%0d error", k), err0,   0);
      check($sformatf("stall%0d gnt", k),   gnt0,   0);
      step();
    end
    ack0 = 1'b1;
    #1;
    check("ack cycle gnt", gnt0, 0);
    step();
    ack0 = 1'b0;
    check("held req granted", gnt0, 1);
    step();
    req0 = 1'b0;
    check("held req sram_addr", saddr0, 6'd2);
    n = 0;
    while (!recv0 && n < 30) begin step(); n++; end
    check("held req rdata", rdata0, 32'hFFFF_5678);
    ack0 = 1'b1;
    step();
    ack0 = 1'b0;

    // dut1: WAIT_CYCLES=2, back-to-back reads with req and ack held high.
    req1 = 1'b1; wen1 = 1'b0; addr1 = 32'h0000_1010; ack1 = 1'b1;
    ng = 0; first_recv = -1; rd1 = 32'h0;
    for (int c = 0; c < 25; c++) begin
      if (gnt1 && ng < 3) begin cyc_g[ng] = c; ng++; end
      if (recv1 && first_recv < 0) begin first_recv = c; rd1 = rdata1; end
      step();
    end
    req1 = 1'b0; ack1 = 1'b0;
    check("w2 grants seen", ng, 3);
    if (ng == 3) begin
      check("w2 recv latency", first_recv - cyc_g[0], 5);
      check("w2 grant spacing a", cyc_g[1] - cyc_g[0], 6);
      check("w2 grant spacing b", cyc_g[2] - cyc_g[1], 6);
    end
    check("w2 rdata", rd1, 32'hCAFE_F00D);

    // Reset asserted while dut0 is in CAPTURE.
    req0 = 1'b1; wen0 = 1'b0; addr0 = 32'h0000_1010; ack0 = 1'b0;
    n = 0;
    while (!gnt0 && n < 20) begin step(); n++; end
    step();
    req0 = 1'b0;
    check("rstcap access cen", cen0, 1);
    step();
    resetn = 1'b0;
    #1;
    check("rstcap gnt low", gnt0, 0);
    check("rstcap recv low", recv0, 0);
    step();
    check("rstcap cen idle", cen0, 0);
    check("rstcap rdata", rdata0, 32'h0);
    resetn = 1'b1;
    #1;
    check("rstcap gnt first cycle", gnt0, 1);
    recv_seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (recv0 || cen0) recv_seen++;
      step();
    end
    check("rstcap no response", recv_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
